fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the RV32I core: owns the program counter, issues requests to instruction memory over a req/ack handshake with arbitrary wait states, and presents one fetched instruction per cycle to decode through a valid/ready output register. It sits directly upstream of `inst_decode`. It accepts control-flow redirects (taken branch, JAL, JALR target from the ALU) and squashes wrong-path instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013, value driven on `inst` when no valid instruction is held (`addi x0,x0,0`).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_ack`  in  1  memory accepts the request; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `redirect_en`  in  1  control-flow change from execute.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a valid instruction.
- `inst_ready`  in  1  decode consumes the instruction this cycle.
- `inst`  out  32  instruction to decode.
- `inst_pc`  out  32  address of `inst`.

## Operation
- States: IDLE, FETCH, WAIT. A `kill` flag marks an outstanding request whose data must be dropped.
- IDLE: entered on reset. `imem_req`=0. Unconditionally moves to FETCH on the next cycle.
- FETCH: `imem_req` = `!inst_valid || inst_ready`; `imem_addr` = `pc`.
  - Request and ack in the same cycle: load `inst`←`imem_rdata`, `inst_pc`←`pc`, `inst_valid`←1, `pc`←`pc+4`. Stay in FETCH.
  - Request without ack: go to WAIT.
- WAIT: `imem_req`=1. `imem_addr` stays stable until ack. On ack, load as in FETCH, unless `kill` is set. Then return to FETCH.
  - The output register is always empty or draining while in WAIT, so an ack can never overrun it.
- Decode handshake: when `inst_valid && inst_ready` and nothing new is loaded, `inst_valid`←0.
- Redirect (`redirect_en`=1) has highest priority and overrides stall.
  - `inst_valid`←0; `pc`←{`redirect_pc[31:2]`,2'b00}.
  - If an ack arrives in the same cycle, its data is discarded and the state becomes FETCH.
  - In WAIT without ack: set `kill` and stay in WAIT. The next ack is dropped, `kill` clears, and the state becomes FETCH.
  - A second redirect while `kill` is set updates `pc` again; `kill` stays set.
- `pc` arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- `inst` = `NOP_INST` whenever `inst_valid`=0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=IDLE, `kill`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst`=`NOP_INST`, `inst_pc`=0.
- Reset asserted mid-request abandons the transaction. Memory must tolerate `imem_req` dropping without an ack.
- First request goes out at cycle R+2 after `rst` deasserts at edge R (one IDLE cycle first).
- Latency: ack in cycle N gives `inst_valid`=1 in cycle N+1.
- Throughput: with a zero-wait memory and `inst_ready`=1, one instruction per cycle.
- Redirect in cycle N:
  - `inst_valid`=0 in N+1.
  - Request to the target in N+1 if nothing is outstanding.
  - Target instruction valid in N+2 with a zero-wait memory.
- `imem_req` and `inst_valid`/`inst` are functions of state and registered outputs only, with one exception: `imem_req` in FETCH depends combinationally on `inst_ready`.

## Structure
- Shared package `core_pkg`:
  - `fetch_state_t` enum {IDLE, FETCH, WAIT}.
  - `NOP_INST` and `RESET_PC` constants, reused by the decode and flush logic.
- One natural sub-module: `pc_gen`, the PC register with next-PC mux (hold / +4 / redirect) and alignment masking.
- The FSM, `kill` flag and output register stay in `fetch_unit`.

## Test plan
- Reset, zero-wait memory returning `addr`+32'h100, `inst_ready`=1 → requests to 0x0, 0x4, 0x8… one per cycle; `inst_pc` increments by 4; first `inst_valid` at cycle R+3.
- Memory with 3 wait states → `imem_addr` stable for 4 cycles per request; each instruction valid exactly once; no duplicates.
- `inst_ready`=0 for 5 cycles with `inst_valid`=1 → `inst`/`inst_pc` held; `imem_req`=0; the next request issues in the cycle `inst_ready` returns to 1.
- `redirect_en` with `redirect_pc`=0x203 in the same cycle as an ack → data dropped; next request to 0x200; `inst_pc`=0x200 two cycles later.
- `redirect_en` to 0x40 during WAIT, ack 2 cycles later → that ack's data is never presented (`inst_valid` stays 0); next request goes to 0x40.
- PC at 0xFFFF_FFFC, zero-wait memory → next request to 0x0; `rst` mid-WAIT → `imem_req`=0 and `inst_valid`=0 the next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, reset PC and the canonical NOP.
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    // Force an instruction address onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_gen.sv
// Program counter with hold / +4 / redirect selection.
module pc_gen
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc
);

    // Redirect wins over sequential advance; the +4 wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_en) begin
            pc <= align_pc(redirect_pc);
        end else if (advance) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, imem req/ack, decode output register.
module fetch_unit
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_t    state;
    fetch_state_t    next_state;
    logic            kill;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] wait_addr;
    logic [XLEN-1:0] inst_q;
    logic            load;
    logic            issue_wait;

    // Accepted response that survives redirect and squash.
    assign load       = imem_req && imem_ack && !redirect_en && !kill;
    // Request left outstanding at the end of a FETCH cycle.
    assign issue_wait = (state == FETCH) && imem_req && !imem_ack;

    pc_gen u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .advance     (load),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = FETCH;
            FETCH:   if (issue_wait) next_state = WAIT;
            WAIT:    if (imem_ack) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Memory request outputs; WAIT replays the captured address so a redirect cannot move it.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        unique case (state)
            FETCH:   imem_req = !inst_valid || inst_ready;
            WAIT: begin
                imem_req  = 1'b1;
                imem_addr = wait_addr;
            end
            default: imem_req = 1'b0;
        endcase
    end

    // Address of the outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_addr <= RESET_PC;
        end else if (issue_wait) begin
            wait_addr <= pc;
        end
    end

    // Squash flag: a redirect left a request in flight whose data is stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            kill <= 1'b0;
        end else if ((state == WAIT) && imem_ack) begin
            kill <= 1'b0;
        end else if (redirect_en && (issue_wait || (state == WAIT))) begin
            kill <= 1'b1;
        end
    end

    // Decode output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst_q     <= NOP_INST;
            inst_pc    <= '0;
        end else if (redirect_en) begin
            inst_valid <= 1'b0;
        end else if (load) begin
            inst_valid <= 1'b1;
            inst_q     <= imem_rdata;
            inst_pc    <= imem_addr;
        end else if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
        end
    end

    assign inst = inst_valid ? inst_q : NOP_INST;

endmodule
